// File: rtl/ps2_key_decoder_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key decoder.
//   - scan-code constants (Scan Code Set 2) for the modifier and control keys
//   - key_event_t   : registered key event {code, ext, brk}
//   - map_result_t  : translation result {hit, chr}
//   - scan_to_ascii : make-code to ASCII translation for the US layout
package ps2_pkg;

   localparam logic [7:0] SC_LSHIFT   = 8'h12;
   localparam logic [7:0] SC_RSHIFT   = 8'h59;
   localparam logic [7:0] SC_CTRL     = 8'h14;
   localparam logic [7:0] SC_CAPS     = 8'h58;
   localparam logic [7:0] SC_ENTER    = 8'h5A;
   localparam logic [7:0] SC_KP_SLASH = 8'h4A;
   localparam logic [7:0] SC_SPACE    = 8'h29;
   localparam logic [7:0] SC_BKSP     = 8'h66;
   localparam logic [7:0] SC_TAB      = 8'h0D;
   localparam logic [7:0] SC_ESC      = 8'h76;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } key_event_t;

   typedef struct packed {
      logic       hit;
      logic [7:0] chr;
   } map_result_t;

   // Letters: lower case, upper if shift XOR caps, Ctrl gives 0x01..0x1A.
   // Digits and punctuation follow Shift only. Only keypad Enter and keypad
   // slash are mapped among the extended codes.
   function automatic map_result_t scan_to_ascii(input logic [7:0] code, input logic ext,
                                                 input logic shift, input logic caps,
                                                 input logic ctrl);
      map_result_t r;
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic        letter;
      logic        sym;
      r      = '0;
      lo     = 8'h00;
      hi     = 8'h00;
      letter = 1'b1;
      sym    = 1'b1;
      if (ext) begin
         if (code == SC_ENTER)         r = '{hit: 1'b1, chr: 8'h0D};
         else if (code == SC_KP_SLASH) r = '{hit: 1'b1, chr: 8'h2F};
      end else begin
         case (code)
            8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
            8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
            8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
            8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
            8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
            8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
            8'h35: lo = "y";  8'h1A: lo = "z";
            default: letter = 1'b0;
         endcase
         if (letter) begin
            r.hit = 1'b1;
            if (ctrl)              r.chr = lo - 8'h60;
            else if (shift ^ caps) r.chr = lo - 8'h20;
            else                   r.chr = lo;
         end else begin
            case (code)
               8'h16: begin lo = 8'h31; hi = 8'h21; end
               8'h1E: begin lo = 8'h32; hi = 8'h40; end
               8'h26: begin lo = 8'h33; hi = 8'h23; end
               8'h25: begin lo = 8'h34; hi = 8'h24; end
               8'h2E: begin lo = 8'h35; hi = 8'h25; end
               8'h36: begin lo = 8'h36; hi = 8'h5E; end
               8'h3D: begin lo = 8'h37; hi = 8'h26; end
               8'h3E: begin lo = 8'h38; hi = 8'h2A; end
               8'h46: begin lo = 8'h39; hi = 8'h28; end
               8'h45: begin lo = 8'h30; hi = 8'h29; end
               8'h0E: begin lo = 8'h60; hi = 8'h7E; end
               8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
               8'h55: begin lo = 8'h3D; hi = 8'h2B; end
               8'h54: begin lo = 8'h5B; hi = 8'h7B; end
               8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
               8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
               8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
               8'h52: begin lo = 8'h27; hi = 8'h22; end
               8'h41: begin lo = 8'h2C; hi = 8'h3C; end
               8'h49: begin lo = 8'h2E; hi = 8'h3E; end
               8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
               SC_SPACE: begin lo = 8'h20; hi = 8'h20; end
               SC_ENTER: begin lo = 8'h0D; hi = 8'h0D; end
               SC_BKSP:  begin lo = 8'h08; hi = 8'h08; end
               SC_TAB:   begin lo = 8'h09; hi = 8'h09; end
               SC_ESC:   begin lo = 8'h1B; hi = 8'h1B; end
               default:  sym = 1'b0;
            endcase
            if (sym) begin
               r.hit = 1'b1;
               r.chr = shift ? hi : lo;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: key-event input, character output handshake and
// status/modifier signals of the PS/2 key decoder.
//   master : key receive stage / character consumer side
//   slave  : decoder side
interface ps2_key_decoder_if;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       ascii_valid;
   logic [7:0] ascii_data;
   logic       ascii_ready;
   logic       shift_held;
   logic       ctrl_held;
   logic       caps_lock;
   logic       overflow;
   logic       overflow_clr;

   modport master (
      output key_valid, key_code, key_ext, key_break, ascii_ready, overflow_clr,
      input  ascii_valid, ascii_data, shift_held, ctrl_held, caps_lock, overflow
   );

   modport slave (
      input  key_valid, key_code, key_ext, key_break, ascii_ready, overflow_clr,
      output ascii_valid, ascii_data, shift_held, ctrl_held, caps_lock, overflow
   );
endinterface

// File: rtl/ps2_key_decoder_char_fifo.sv
// ps2_char_fifo: synchronous first-word-fall-through character FIFO.
//   clk, reset_n    : clock, async active-low reset
//   push, push_data : write request; accepted when not full or when popping
//   pop             : remove head; ignored when empty
//   head            : current head character (0 when empty)
//   empty, full     : occupancy flags
//   count           : number of stored entries
module ps2_char_fifo #(
   parameter  int FIFO_DEPTH = 8,
   localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [7:0]        push_data,
   input  logic              pop,
   output logic [7:0]        head,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count
);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [7:0]        mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: tracks Shift/Ctrl/Caps Lock from PS/2 key events, turns
// make codes into ASCII and buffers them in a character FIFO.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : key events in, ascii valid/ready out, modifier state,
//                  sticky overflow with clear
// A key event at cycle N is registered (and modifiers updated) for N+1; its
// character is written to the FIFO at the end of N+1 and is visible at N+2.
// Build option: TYPEMATIC_FILTER_EN suppresses repeated makes of the same key.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   ps2_key_decoder_if.slave bus
);
   localparam int ADDR_W = $clog2(FIFO_DEPTH);

   key_event_t      s1;
   logic            s1_valid;
   logic            lshift;
   logic            rshift;
   logic            ctrl;
   logic            caps_held;
   logic            caps_lock;
   logic            overflow;
   map_result_t     xlat;
   logic            repeat_hit;
   logic            push_req;
   logic [7:0]      fifo_head;
   logic            fifo_empty;
   logic            fifo_full;
   logic [ADDR_W:0] fifo_count;
   logic            unused_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1        <= '0;
         s1_valid  <= 1'b0;
         lshift    <= 1'b0;
         rshift    <= 1'b0;
         ctrl      <= 1'b0;
         caps_held <= 1'b0;
         caps_lock <= 1'b0;
      end else begin
         s1_valid <= bus.key_valid;
         if (bus.key_valid) begin
            s1 <= '{code: bus.key_code, ext: bus.key_ext, brk: bus.key_break};
            if (!bus.key_ext && bus.key_code == SC_LSHIFT) lshift <= !bus.key_break;
            if (!bus.key_ext && bus.key_code == SC_RSHIFT) rshift <= !bus.key_break;
            if (bus.key_code == SC_CTRL)                   ctrl   <= !bus.key_break;
            if (!bus.key_ext && bus.key_code == SC_CAPS) begin
               caps_held <= !bus.key_break;
               // Typematic repeats of Caps arrive as makes while held.
               if (!bus.key_break && !caps_held) caps_lock <= !caps_lock;
            end
         end
      end
   end

   assign xlat = scan_to_ascii(s1.code, s1.ext, lshift | rshift, caps_lock, ctrl);

`ifdef TYPEMATIC_FILTER_EN
   logic       last_valid;
   logic [8:0] last_key;

   // Compared against the make before this one, so last_key advances one
   // cycle after the event register.
   assign repeat_hit = last_valid && (last_key == {s1.ext, s1.code});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_valid <= 1'b0;
         last_key   <= '0;
      end else if (s1_valid) begin
         if (!s1.brk) begin
            last_valid <= 1'b1;
            last_key   <= {s1.ext, s1.code};
         end else if (repeat_hit) begin
            last_valid <= 1'b0;
         end
      end
   end
`else
   assign repeat_hit = 1'b0;
`endif

   assign push_req = s1_valid && !s1.brk && xlat.hit && !repeat_hit;

   ps2_char_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_req),
      .push_data (xlat.chr),
      .pop       (bus.ascii_ready),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // Occupancy is only of interest when probing the FIFO directly.
   assign unused_count = ^fifo_count;

   // Full implies non-empty, so ascii_ready alone means a pop frees a slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                         overflow <= 1'b0;
      else if (push_req && fifo_full && !bus.ascii_ready)   overflow <= 1'b1;
      else if (bus.overflow_clr)                            overflow <= 1'b0;
   end

   assign bus.ascii_valid = !fifo_empty;
   assign bus.ascii_data  = fifo_head;
   assign bus.shift_held  = lshift | rshift;
   assign bus.ctrl_held   = ctrl;
   assign bus.caps_lock   = caps_lock;
   assign bus.overflow    = overflow;
endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   ps2_key_decoder_if bus();
   ps2_key_decoder #(.FIFO_DEPTH(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   logic [7:0] exp_q[$];
   bit rnd_ready = 1'b0;

   // reference model state
   bit m_lshift, m_rshift, m_ctrl, m_caps, m_caps_held, m_last_valid;
   logic [8:0] m_last_key;

   logic [7:0] letter_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                  8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                  8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   logic [7:0] sym_sc [21] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45,
                               8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A};
   logic [7:0] sym_lo [21] = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h30,
                               8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F};
   logic [7:0] sym_hi [21] = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29,
                               8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F};
   logic [7:0] ctl_sc [5] = '{8'h29,8'h5A,8'h66,8'h0D,8'h76};
   logic [7:0] ctl_ch [5] = '{8'h20,8'h0D,8'h08,8'h09,8'h1B};
   logic [7:0] mod_sc [4] = '{8'h12,8'h59,8'h14,8'h58};
   logic [7:0] ext_sc [5] = '{8'h5A,8'h4A,8'h75,8'h14,8'h6B};

   function automatic void ref_map(input logic ext, input logic [7:0] code,
                                   output logic hit, output logic [7:0] ch);
      bit sh;
      sh  = m_lshift | m_rshift;
      hit = 1'b0;
      ch  = 8'h00;
      if (ext) begin
         if (code == 8'h5A)      begin hit = 1'b1; ch = 8'h0D; end
         else if (code == 8'h4A) begin hit = 1'b1; ch = 8'h2F; end
         return;
      end
      for (int i = 0; i < 26; i++)
         if (letter_sc[i] == code) begin
            hit = 1'b1;
            if (m_ctrl)          ch = 8'(i + 1);
            else if (sh ^ m_caps) ch = 8'(65 + i);
            else                 ch = 8'(97 + i);
         end
      for (int i = 0; i < 21; i++)
         if (sym_sc[i] == code) begin hit = 1'b1; ch = sh ? sym_hi[i] : sym_lo[i]; end
      for (int i = 0; i < 5; i++)
         if (ctl_sc[i] == code) begin hit = 1'b1; ch = ctl_ch[i]; end
   endfunction

   function automatic void model_reset();
      m_lshift = 0; m_rshift = 0; m_ctrl = 0; m_caps = 0; m_caps_held = 0;
      m_last_valid = 0; m_last_key = '0;
      exp_q.delete();
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (rnd_ready) bus.ascii_ready = ($urandom_range(3) != 0);
      end
   endtask

   // Drive one key event for one cycle, update the model, check modifiers at N+1.
   task automatic send(input logic ext, input logic [7:0] code, input logic brk);
      logic hit;
      logic [7:0] ch;
      if (!brk) begin
         ref_map(ext, code, hit, ch);
`ifdef TYPEMATIC_FILTER_EN
         if (m_last_valid && m_last_key == {ext, code}) hit = 1'b0;
         m_last_valid = 1; m_last_key = {ext, code};
`endif
         if (hit) exp_q.push_back(ch);
      end else begin
`ifdef TYPEMATIC_FILTER_EN
         if (m_last_valid && m_last_key == {ext, code}) m_last_valid = 0;
`endif
      end
      if (!ext && code == 8'h12) m_lshift = !brk;
      if (!ext && code == 8'h59) m_rshift = !brk;
      if (code == 8'h14) m_ctrl = !brk;
      if (!ext && code == 8'h58) begin
         if (!brk && !m_caps_held) m_caps = !m_caps;
         m_caps_held = !brk;
      end
      bus.key_valid = 1'b1; bus.key_ext = ext; bus.key_code = code; bus.key_break = brk;
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      if (rnd_ready) bus.ascii_ready = ($urandom_range(3) != 0);
      checks += 3;
      if (bus.shift_held !== (m_lshift | m_rshift)) begin errors++;
         $display("FAIL shift_held code=%h brk=%0d: got %b want %b", code, brk, bus.shift_held, m_lshift | m_rshift); end
      if (bus.ctrl_held !== m_ctrl) begin errors++;
         $display("FAIL ctrl_held code=%h brk=%0d: got %b want %b", code, brk, bus.ctrl_held, m_ctrl); end
      if (bus.caps_lock !== m_caps) begin errors++;
         $display("FAIL caps_lock code=%h brk=%0d: got %b want %b", code, brk, bus.caps_lock, m_caps); end
   endtask

   task automatic wait_drain();
      int n = 0;
      rnd_ready = 1'b0;
      bus.ascii_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
      checks++;
      if (exp_q.size() != 0) begin errors++;
         $display("FAIL drain_timeout: %0d chars missing, want 0", exp_q.size()); exp_q.delete(); end
      @(posedge clk); #1;
      checks++;
      if (bus.ascii_valid !== 1'b0) begin errors++;
         $display("FAIL drain_extra: ascii_valid=%b data=%h, want valid 0", bus.ascii_valid, bus.ascii_data); end
   endtask

   // Scoreboard: every handshake is compared with the oldest expected char.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   always @(negedge clk) begin
      if (!reset_n) prev_stall = 1'b0;
      else begin
         if (prev_stall && bus.ascii_valid) begin
            checks++;
            if (bus.ascii_data !== prev_data) begin errors++;
               $display("FAIL stall_stable: data %h, want %h", bus.ascii_data, prev_data); end
         end
         if (bus.ascii_valid && bus.ascii_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin errors++;
               $display("FAIL char_unexpected: got %h, want none", bus.ascii_data); end
            else begin
               if (bus.ascii_data !== exp_q[0]) begin errors++;
                  $display("FAIL char_data: got %h, want %h", bus.ascii_data, exp_q[0]); end
               exp_q.pop_front();
            end
         end
         prev_stall = bus.ascii_valid && !bus.ascii_ready;
         prev_data  = bus.ascii_data;
      end
   end

   task automatic test_reset();
      checks += 6;
      if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.ascii_valid); end
      if (bus.ascii_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", bus.ascii_data); end
      if (bus.shift_held !== 1'b0) begin errors++; $display("FAIL rst_shift: got %b want 0", bus.shift_held); end
      if (bus.ctrl_held !== 1'b0)  begin errors++; $display("FAIL rst_ctrl: got %b want 0", bus.ctrl_held); end
      if (bus.caps_lock !== 1'b0)  begin errors++; $display("FAIL rst_caps: got %b want 0", bus.caps_lock); end
      if (bus.overflow !== 1'b0)   begin errors++; $display("FAIL rst_ovf: got %b want 0", bus.overflow); end
      @(negedge clk); reset_n = 1'b1;
      idle(2);
      checks++;
      if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b want 0", bus.ascii_valid); end
   endtask

   task automatic test_basic_make();
      bus.ascii_ready = 1'b1;
      send(1'b0, 8'h1C, 1'b0);
      checks++;
      if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL lat_n1: valid %b want 0", bus.ascii_valid); end
      @(posedge clk); #1;
      checks += 2;
      if (bus.ascii_valid !== 1'b1) begin errors++; $display("FAIL lat_n2: valid %b want 1", bus.ascii_valid); end
      if (bus.ascii_data !== 8'h61) begin errors++; $display("FAIL lat_n2_data: got %h want 61", bus.ascii_data); end
      send(1'b0, 8'h1C, 1'b1);
      wait_drain();
   endtask

   task automatic test_shift();
      bus.ascii_ready = 1'b1;
      send(1'b0, 8'h12, 1'b0);
      send(1'b0, 8'h1C, 1'b0);
      send(1'b0, 8'h12, 1'b1);
      send(1'b0, 8'h1C, 1'b0);
      send(1'b0, 8'h1C, 1'b1);
      send(1'b0, 8'h59, 1'b0);
      send(1'b0, 8'h1B, 1'b0);
      send(1'b0, 8'h1B, 1'b1);
      send(1'b0, 8'h59, 1'b1);
      wait_drain();
   endtask

   task automatic test_caps_shift();
      bus.ascii_ready = 1'b1;
      send(1'b0, 8'h58, 1'b0);
      send(1'b0, 8'h58, 1'b1);
      send(1'b0, 8'h12, 1'b0);
      send(1'b0, 8'h16, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.ascii_data !== 8'h21) begin errors++; $display("FAIL shift_digit: got %h want 21", bus.ascii_data); end
      send(1'b0, 8'h16, 1'b1);
      send(1'b0, 8'h32, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.ascii_data !== 8'h62) begin errors++; $display("FAIL shift_caps_letter: got %h want 62", bus.ascii_data); end
      send(1'b0, 8'h32, 1'b1);
      send(1'b0, 8'h12, 1'b1);
      send(1'b0, 8'h32, 1'b0);
      send(1'b0, 8'h32, 1'b1);
      send(1'b0, 8'h58, 1'b0);
      send(1'b0, 8'h58, 1'b0);
      send(1'b0, 8'h58, 1'b0);
      send(1'b0, 8'h58, 1'b1);
      wait_drain();
   endtask

   task automatic test_ctrl_ext();
      bus.ascii_ready = 1'b1;
      send(1'b0, 8'h14, 1'b0);
      send(1'b0, 8'h21, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.ascii_data !== 8'h03) begin errors++; $display("FAIL ctrl_c: got %h want 03", bus.ascii_data); end
      send(1'b0, 8'h21, 1'b1);
      send(1'b0, 8'h14, 1'b1);
      send(1'b1, 8'h4A, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (bus.ascii_data !== 8'h2F) begin errors++; $display("FAIL ext_slash: got %h want 2f", bus.ascii_data); end
      send(1'b1, 8'h4A, 1'b1);
      send(1'b1, 8'h75, 1'b0);
      send(1'b1, 8'h75, 1'b1);
      send(1'b1, 8'h14, 1'b0);
      send(1'b1, 8'h14, 1'b1);
      send(1'b0, 8'h29, 1'b0);
      send(1'b0, 8'h29, 1'b1);
      wait_drain();
   endtask

   task automatic test_typematic();
      int p0;
      int want;
`ifdef TYPEMATIC_FILTER_EN
      want = 1;
`else
      want = 3;
`endif
      bus.ascii_ready = 1'b1;
      p0 = pops;
      send(1'b0, 8'h1C, 1'b0);
      send(1'b0, 8'h1C, 1'b0);
      send(1'b0, 8'h1C, 1'b0);
      send(1'b0, 8'h1C, 1'b1);
      wait_drain();
      checks++;
      if (pops - p0 !== want) begin errors++; $display("FAIL typematic_count: got %0d want %0d", pops - p0, want); end
   endtask

   task automatic test_overflow();
      int p0;
      bus.ascii_ready = 1'b0;
      for (int i = 0; i < 9; i++) send(1'b0, letter_sc[i], 1'b0);
      exp_q.delete(exp_q.size() - 1);
      idle(3);
      checks += 3;
      if (bus.overflow !== 1'b1)    begin errors++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
      if (bus.ascii_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", bus.ascii_valid); end
      if (bus.ascii_data !== 8'h61) begin errors++; $display("FAIL ovf_head: got %h want 61", bus.ascii_data); end
      bus.overflow_clr = 1'b1;
      idle(1);
      bus.overflow_clr = 1'b0;
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", bus.overflow); end
      // push and pop land in the same cycle while full
      send(1'b0, letter_sc[9], 1'b0);
      bus.ascii_ready = 1'b1;
      idle(1);
      bus.ascii_ready = 1'b0;
      idle(1);
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got %b want 0", bus.overflow); end
      // dropped push with a simultaneous clear: set wins
      send(1'b0, letter_sc[10], 1'b0);
      exp_q.delete(exp_q.size() - 1);
      bus.overflow_clr = 1'b1;
      idle(1);
      bus.overflow_clr = 1'b0;
      checks++;
      if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", bus.overflow); end
      bus.overflow_clr = 1'b1;
      idle(1);
      bus.overflow_clr = 1'b0;
      p0 = pops;
      wait_drain();
      checks++;
      if (pops - p0 !== 8) begin errors++; $display("FAIL full_count: drained %0d want 8", pops - p0); end
      for (int i = 0; i < 11; i++) send(1'b0, letter_sc[i], 1'b1);
   endtask

   task automatic test_random();
      int n;
      int r;
      logic [7:0] code;
      logic ext;
      rnd_ready = 1'b1;
      for (int k = 0; k < 250; k++) begin
         n = 0;
         while (exp_q.size() >= 5 && n < 100) begin idle(1); n++; end
         r = $urandom_range(9);
         ext = 1'b0;
         if (r <= 3)      code = letter_sc[$urandom_range(25)];
         else if (r <= 5) code = sym_sc[$urandom_range(20)];
         else if (r == 6) code = ctl_sc[$urandom_range(4)];
         else if (r == 7) code = mod_sc[$urandom_range(3)];
         else if (r == 8) code = ($urandom_range(1) == 0) ? 8'h05 : 8'h77;
         else begin ext = 1'b1; code = ext_sc[$urandom_range(4)]; end
         send(ext, code, $urandom_range(3) == 0);
         if ($urandom_range(2) == 0) idle(1);
      end
      wait_drain();
      send(1'b0, 8'h12, 1'b1);
      send(1'b0, 8'h59, 1'b1);
      send(1'b0, 8'h14, 1'b1);
      send(1'b0, 8'h58, 1'b1);
      wait_drain();
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf: got %b want 0", bus.overflow); end
   endtask

   task automatic test_reset_midop();
      bus.ascii_ready = 1'b0;
      send(1'b0, 8'h12, 1'b0);
      send(1'b0, 8'h14, 1'b0);
      send(1'b0, 8'h58, 1'b0);
      send(1'b0, 8'h29, 1'b0);
      send(1'b0, 8'h16, 1'b0);
      send(1'b0, 8'h1E, 1'b0);
      idle(3);
      checks++;
      if (bus.ascii_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b want 1", bus.ascii_valid); end
      send(1'b0, 8'h26, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      checks += 4;
      if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", bus.ascii_valid); end
      if (bus.shift_held !== 1'b0)  begin errors++; $display("FAIL mid_rst_shift: got %b want 0", bus.shift_held); end
      if (bus.ctrl_held !== 1'b0)   begin errors++; $display("FAIL mid_rst_ctrl: got %b want 0", bus.ctrl_held); end
      if (bus.caps_lock !== 1'b0)   begin errors++; $display("FAIL mid_rst_caps: got %b want 0", bus.caps_lock); end
      @(negedge clk); reset_n = 1'b1;
      bus.ascii_ready = 1'b1;
      idle(4);
      checks++;
      if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL inflight_kept: got %b want 0", bus.ascii_valid); end
   endtask

   initial begin
      reset_n = 1'b0;
      bus.key_valid = 1'b0; bus.key_code = 8'h00; bus.key_ext = 1'b0; bus.key_break = 1'b0;
      bus.ascii_ready = 1'b0; bus.overflow_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_basic_make();
      test_shift();
      test_caps_shift();
      test_ctrl_ext();
      test_typematic();
      test_overflow();
      test_random();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
